// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI definitions for the transmit path and the input parser.
// Holds the transmitter state encoding, protocol constants and byte-class helpers.
package midi_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    localparam int         MIDI_BAUD          = 31250;
    localparam logic [7:0] MIDI_STATUS_MASK   = 8'h80;
    localparam logic [7:0] MIDI_SYSEX_BASE    = 8'hF0;
    localparam logic [7:0] MIDI_REALTIME_BASE = 8'hF8;

    // 0x80..0xEF: voice/mode messages that carry a channel number
    function automatic logic is_channel_status(input logic [7:0] b);
        return ((b & MIDI_STATUS_MASK) != 8'h00) && (b < MIDI_SYSEX_BASE);
    endfunction

    // 0xF0..0xF7: system common / sysex, these cancel running status
    function automatic logic is_system_common(input logic [7:0] b);
        return (b >= MIDI_SYSEX_BASE) && (b < MIDI_REALTIME_BASE);
    endfunction

    // 0xF8..0xFF: single-byte realtime, may interleave anywhere
    function automatic logic is_realtime(input logic [7:0] b);
        return b >= MIDI_REALTIME_BASE;
    endfunction

endpackage

// File: rtl/midi_out_if.sv
// midi_out_if: byte handshake between a byte producer and the MIDI transmitter.
interface midi_out_if;
    logic [7:0] byteInput;
    logic       byteInputValid;
    logic       byteInputReady;

    modport master (output byteInput, output byteInputValid, input byteInputReady);
    modport slave  (input byteInput, input byteInputValid, output byteInputReady);
endinterface

// File: rtl/midi_byte_fifo.sv
// midi_byte_fifo: small synchronous FIFO with full/empty/count.
// Head entry is read combinationally so the transmitter can load it on the pop edge.
module midi_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int             PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    // Pointer and occupancy update; simultaneous push and pop leave count unchanged
    always_comb begin
        do_push  = push && (count_q != FULL_COUNT);
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr_q];
    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/midi_out.sv
// midi_out: MIDI OUT transmitter. Bytes arrive over a valid/ready handshake,
// queue in midi_byte_fifo and leave as 8N1 frames at BAUD on uartStream.
// Optional feature macro: MIDI_OUT_RUNNING_STATUS_EN enables running-status
// compression at enqueue; without it every accepted byte is sent verbatim.
module midi_out
    import midi_pkg::*;
#(
    parameter int CLOCK_HZ   = 50000000,
    parameter int BAUD       = MIDI_BAUD,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    midi_out_if.slave        in_if,
    output logic             uartStream,
    output logic             busy
);
    localparam int               DIVIDER  = CLOCK_HZ / BAUD;
    localparam int               CNT_W    = $clog2(DIVIDER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER - 1);

    logic                         accept;
    logic                         enqueue;
    logic                         fifo_pop;
    logic [7:0]                   fifo_rdata;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             line_q, line_d;
    logic             bit_end;

    assign in_if.byteInputReady = !fifo_full;
    assign accept               = in_if.byteInputValid && in_if.byteInputReady;

`ifdef MIDI_OUT_RUNNING_STATUS_EN
    // Last enqueued channel status; 0x00 means none since it is never a status byte
    logic [7:0] status_q, status_d;

    // Running-status filter: repeated channel status is swallowed after the handshake
    always_comb begin
        status_d = status_q;
        enqueue  = accept;
        if (accept) begin
            if (is_channel_status(in_if.byteInput)) begin
                if (in_if.byteInput == status_q) begin
                    enqueue = 1'b0;
                end else begin
                    status_d = in_if.byteInput;
                end
            end else if (is_system_common(in_if.byteInput)) begin
                status_d = 8'h00;
            end
        end
    end

    // Stored running status
    always_ff @(posedge clock) begin
        if (reset) begin
            status_q <= 8'h00;
        end else begin
            status_q <= status_d;
        end
    end
`else
    assign enqueue = accept;
`endif

    midi_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (enqueue),
        .push_data (in_if.byteInput),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Transmit next-state: a pop loads the shifter and drives the start bit on the same edge
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        line_d     = line_q;
        fifo_pop   = 1'b0;
        bit_end    = (baud_cnt_q == CNT_LAST);
        case (state_q)
            TX_IDLE: begin
                baud_cnt_d = '0;
                line_d     = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    line_d   = 1'b0;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    line_d     = shift_q[0];
                    state_d    = TX_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        line_d  = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        line_d    = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        line_d   = 1'b0;
                        state_d  = TX_START;
                    end else begin
                        line_d  = 1'b1;
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                baud_cnt_d = '0;
                line_d     = 1'b1;
                state_d    = TX_IDLE;
            end
        endcase
    end

    // Transmit state and registered line output; reset forces the line idle immediately
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            line_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            line_q     <= line_d;
        end
    end

    assign uartStream = line_q;
    assign busy       = (fifo_count != '0) || (state_q != TX_IDLE);

endmodule

// File: tb/tb_midi_out.sv
// tb_midi_out: bench for midi_out. One instance at default rates, one at DIVIDER=16.
`timescale 1ns/1ps
module tb_midi_out;
    localparam int D      = 16;
    localparam int SLOW_D = 1600;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_slow, rst_fast;
    logic line_slow, busy_slow, line_fast, busy_fast;

    midi_out_if slow_if();
    midi_out_if fast_if();

    midi_out u_slow (
        .clock      (clk),
        .reset      (rst_slow),
        .in_if      (slow_if),
        .uartStream (line_slow),
        .busy       (busy_slow)
    );

    midi_out #(
        .CLOCK_HZ   (500000),
        .BAUD       (31250),
        .FIFO_DEPTH (4)
    ) u_fast (
        .clock      (clk),
        .reset      (rst_fast),
        .in_if      (fast_if),
        .uartStream (line_fast),
        .busy       (busy_fast)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: what the line should carry, and what the monitor decoded from it
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         framing_errs = 0;
    logic       mon_en = 1'b0;
    int         model_status = -1;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 is sent first: start, d0..d7, stop
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        rx_q.delete();
        rx_t.delete();
        framing_errs = 0;
        model_status = -1;
    endtask

    // Behavioural byte model: which accepted bytes must appear on the line
    task automatic model_push(input logic [7:0] b);
`ifdef MIDI_OUT_RUNNING_STATUS_EN
        if (b >= 8'h80 && b <= 8'hEF) begin
            if (int'(b) == model_status) return;
            model_status = int'(b);
        end else if (b >= 8'hF0 && b <= 8'hF7) begin
            model_status = -1;
        end
`endif
        exp_q.push_back(b);
    endtask

    // Present a byte until the handshake completes; valid stays high afterwards
    task automatic send_fast(input logic [7:0] b, output logic ready_after);
        int waited;
        waited = 0;
        fast_if.byteInput      = b;
        fast_if.byteInputValid = 1'b1;
        while (fast_if.byteInputReady !== 1'b1 && waited < 2000) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("send_ready", fast_if.byteInputReady, 1'b1);
        @(posedge clk); #1;
        ready_after = fast_if.byteInputReady;
        model_push(b);
    endtask

    task automatic wait_fast_idle(input string name);
        int n;
        n = 0;
        while (busy_fast !== 1'b0 && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, busy_fast, 1'b0);
    endtask

    task automatic reset_fast();
        rst_fast = 1'b1;
        fast_if.byteInputValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_fast = 1'b0;
        model_clear();
    endtask

    task automatic compare_rx(input string name);
        chk({name, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            $display("%s byte %0d: line %02h model %02h", name, i, rx_q[i], exp_q[i]);
            chk($sformatf("%s_byte%0d", name, i), rx_q[i], exp_q[i]);
        end
        chk({name, "_framing"}, framing_errs, 0);
    endtask

    // Line decoder for the fast instance: samples each bit at its centre
    initial begin : monitor
        logic [7:0] mb;
        logic       mok;
        int         mt;
        forever begin
            @(posedge clk); #2;
            if (mon_en && !rst_fast && line_fast === 1'b0) begin
                mt = cyc;
                repeat (D / 2) @(posedge clk);
                #2;
                mok = (line_fast === 1'b0);
                for (int j = 0; j < 8; j++) begin
                    repeat (D) @(posedge clk);
                    #2;
                    mb[j] = line_fast;
                end
                repeat (D) @(posedge clk);
                #2;
                mok = mok && (line_fast === 1'b1);
                if (!mok) framing_errs++;
                rx_q.push_back(mb);
                rx_t.push_back(mt);
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: no summary after 150000 cycles");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        vec_t       vecs[6];
        logic [7:0] b2b_bytes[6];
        logic [7:0] rs_bytes[11];
        logic [9:0] frame;
        logic [9:0] cap;
        logic       r;
        logic       busy_before;
        int         errs;
        int         n;
        int         t0;
        logic [7:0] b;

        vecs[0] = '{8'h90, 10'b1100100000};
        vecs[1] = '{8'h55, 10'b1010101010};
        vecs[2] = '{8'hAA, 10'b1101010100};
        vecs[3] = '{8'h00, 10'b1000000000};
        vecs[4] = '{8'hFF, 10'b1111111110};
        vecs[5] = '{8'h3C, 10'b1001111000};
        b2b_bytes = '{8'h90, 8'h3C, 8'h64, 8'h80, 8'h3C, 8'h00};
        rs_bytes  = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h64, 8'hF8, 8'h90, 8'h40, 8'hF0, 8'h90};

        rst_slow = 1'b1;
        rst_fast = 1'b1;
        slow_if.byteInput      = 8'h00;
        slow_if.byteInputValid = 1'b0;
        fast_if.byteInput      = 8'h00;
        fast_if.byteInputValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_slow = 1'b0;
        rst_fast = 1'b0;

        // Reset state
        chk("rst_line_slow",  line_slow, 1'b1);
        chk("rst_busy_slow",  busy_slow, 1'b0);
        chk("rst_ready_slow", slow_if.byteInputReady, 1'b1);
        chk("rst_line_fast",  line_fast, 1'b1);
        chk("rst_busy_fast",  busy_fast, 1'b0);
        chk("rst_ready_fast", fast_if.byteInputReady, 1'b1);

        // Line stays idle with no input
        errs = 0;
        for (int k = 0; k < 20000; k++) begin
            @(posedge clk); #1;
            if (line_slow !== 1'b1 || line_fast !== 1'b1 || busy_slow !== 1'b0) errs++;
        end
        chk("idle_20000_errs", errs, 0);

        // Single 0x90 at default rate, checked every cycle of the frame
        slow_if.byteInput      = 8'h90;
        slow_if.byteInputValid = 1'b1;
        @(posedge clk); #1;
        slow_if.byteInputValid = 1'b0;
        frame       = 10'b1100100000;
        busy_before = 1'b0;
        for (int j = 0; j < 10; j++) begin
            errs = 0;
            for (int k = 0; k < SLOW_D; k++) begin
                @(posedge clk); #1;
                if (line_slow !== frame[j]) errs++;
                if (j == 9 && k == SLOW_D - 1) busy_before = busy_slow;
            end
            $display("slow frame bit %0d: %0d wrong samples", j, errs);
            chk($sformatf("slow_bit%0d_errs", j), errs, 0);
        end
        chk("slow_busy_last_cycle", busy_before, 1'b1);
        @(posedge clk); #1;
        chk("slow_busy_fall", busy_slow, 1'b0);
        chk("slow_line_idle", line_slow, 1'b1);

        // Table of single frames on the fast instance
        reset_fast();
        for (int i = 0; i < 6; i++) begin
            send_fast(vecs[i].data, r);
            fast_if.byteInputValid = 1'b0;
            n = 0;
            while (line_fast !== 1'b0 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            chk("vec_start_latency", n, 1);
            cap = '0;
            repeat (D / 2) @(posedge clk);
            #1;
            cap[0] = line_fast;
            for (int j = 1; j < 10; j++) begin
                repeat (D) @(posedge clk);
                #1;
                cap[j] = line_fast;
            end
            $display("vec %0d: byte %02h frame %b expected %b", i, vecs[i].data, cap, vecs[i].frame);
            chk($sformatf("vec%0d_frame", i), cap, vecs[i].frame);
            repeat (D / 2 - 1) @(posedge clk);
            #1;
            chk($sformatf("vec%0d_busy_end", i), busy_fast, 1'b1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_busy_idle", i), busy_fast, 1'b0);
        end

        // Back-to-back frames with valid held high
        reset_fast();
        mon_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            send_fast(b2b_bytes[k], r);
            chk($sformatf("b2b_ready_after%0d", k), r, (k < 4) ? 1 : 0);
        end
        fast_if.byteInputValid = 1'b0;
        wait_fast_idle("b2b_idle");
        mon_en = 1'b0;
        compare_rx("b2b");
        for (int k = 0; k + 1 < rx_t.size(); k++) begin
            chk($sformatf("b2b_gap%0d", k), rx_t[k + 1] - rx_t[k], 10 * D);
        end

        // Running-status sequence
        reset_fast();
        mon_en = 1'b1;
        for (int k = 0; k < 11; k++) begin
            send_fast(rs_bytes[k], r);
        end
        fast_if.byteInputValid = 1'b0;
        wait_fast_idle("rs_idle");
        mon_en = 1'b0;
`ifdef MIDI_OUT_RUNNING_STATUS_EN
        chk("rs_len", rx_q.size(), 9);
`else
        chk("rs_len", rx_q.size(), 11);
`endif
        compare_rx("rs");

        // Reset during data bit 3 of 0x55 with two more bytes queued
        reset_fast();
        send_fast(8'h55, r);
        fast_if.byteInputValid = 1'b0;
        n = 0;
        while (line_fast !== 1'b0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        t0 = cyc;
        send_fast(8'h11, r);
        send_fast(8'h22, r);
        fast_if.byteInputValid = 1'b0;
        while (cyc < t0 + 4 * D + D / 2) begin
            @(posedge clk); #1;
        end
        chk("mid_bit3_value", line_fast, 1'b0);
        rst_fast = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_line", line_fast, 1'b1);
        chk("mid_rst_busy", busy_fast, 1'b0);
        @(posedge clk); #1;
        rst_fast = 1'b0;
        model_clear();
        errs = 0;
        for (int k = 0; k < 30 * D; k++) begin
            @(posedge clk); #1;
            if (line_fast !== 1'b1 || busy_fast !== 1'b0) errs++;
        end
        chk("mid_queue_lost_errs", errs, 0);
        mon_en = 1'b1;
        send_fast(8'hAA, r);
        fast_if.byteInputValid = 1'b0;
        wait_fast_idle("post_rst_idle");
        mon_en = 1'b0;
        compare_rx("post_rst");

        // Random bytes and gaps against the byte model
        reset_fast();
        mon_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       b = 8'h90;
                1:       b = 8'h80 | 8'($urandom_range(0, 1));
                2:       b = 8'hF0 + 8'($urandom_range(0, 15));
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_fast(b, r);
            if ($urandom_range(0, 2) == 0) begin
                fast_if.byteInputValid = 1'b0;
                repeat ($urandom_range(1, 200)) @(posedge clk);
                #1;
            end
        end
        fast_if.byteInputValid = 1'b0;
        wait_fast_idle("rand_idle");
        mon_en = 1'b0;
        compare_rx("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/midi_out.md
# midi_out

MIDI serial transmitter: the sending counterpart of the MIDI receiver. It accepts bytes over a valid/ready handshake and buffers them in a small FIFO. It serialises each byte as an 8N1 UART frame at 31250 baud on the MIDI OUT line. It sits beside the MIDI input path at the top level, driving the FX2-BB MIDI OUT pin for thru/echo and for debug traffic.

## Interface
- `CLOCK_HZ`, 50000000: system clock frequency.
- `BAUD`, 31250: line rate. `DIVIDER = CLOCK_HZ/BAUD` cycles per bit (1600 at defaults); must be ≥ 2.
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, ≥ 2.
- `clock` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `byteInput` in 8: byte to transmit.
- `byteInputValid` in 1: `byteInput` is valid this cycle.
- `byteInputReady` out 1: block can accept a byte. Equals `!fifo_full`, combinational from registered state.
- `uartStream` out 1: serial MIDI line, registered, idle high.
- `busy` out 1: FIFO non-empty or a frame is in progress.

## Operation
- Transfer occurs on a clock edge where `byteInputValid && byteInputReady`. The byte is then enqueued, subject to filtering under Configuration.
- Transmit FSM states:
  - IDLE: line high. If the FIFO is non-empty, pop into the shift register, drive the line low and go to START.
  - START: hold for DIVIDER cycles, then go to DATA with bit index 0.
  - DATA: drive bits LSB first, each for DIVIDER cycles. After bit 7, go to STOP.
  - STOP: line high for DIVIDER cycles. Then, if the FIFO is non-empty, pop, drive low and go to START in the same cycle (back-to-back frames with no extra idle); otherwise go to IDLE.
- Bit counter runs 0..DIVIDER-1 and wraps exactly on the bit boundary. It holds at 0 in IDLE.
- FIFO behaviour:
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - No push is possible when full, because ready is low.
  - Pop occurs only in IDLE, or at the end of STOP, when the FIFO is non-empty.
- `busy` = (FIFO count ≠ 0) || (state ≠ IDLE).

## Timing
- Reset values:
  - `uartStream` = 1, `busy` = 0, `byteInputReady` = 1.
  - FSM = IDLE, FIFO empty, counters 0.
  - Stored running status cleared.
- Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. The start bit is visible from N+1.
- Frame length is exactly 10×DIVIDER cycles (16000 at defaults). Each bit is exactly DIVIDER cycles.
- Mid-frame reset: the line returns high at the reset edge. The FIFO and the partial byte are discarded. The next accepted byte is sent as a complete frame.
- `byteInputReady` rises on the cycle after a pop from a full FIFO.

## Configuration
- `MIDI_OUT_RUNNING_STATUS_EN` defined: MIDI running-status compression, applied at enqueue.
  - Keeps the last enqueued channel status byte (0x80–0xEF).
  - A channel status byte equal to the stored one is accepted but not enqueued. The handshake still completes.
  - A different channel status byte is enqueued and stored.
  - 0xF0–0xF7 is enqueued and clears the stored status.
  - 0xF8–0xFF is enqueued and leaves the stored status unchanged.
  - Data bytes (0x00–0x7F) are always enqueued.
- Undefined: every accepted byte is enqueued verbatim; no status register exists.

## Structure
- Shared package `midi_pkg` holds:
  - The tx state enum.
  - Constants `MIDI_BAUD` = 31250, `MIDI_STATUS_MASK` = 8'h80, `MIDI_SYSEX_BASE` = 8'hF0, `MIDI_REALTIME_BASE` = 8'hF8.
  - Byte-classification functions (is_channel_status, is_system_common, is_realtime), shared with the parser.
- Sub-module `midi_byte_fifo`: synchronous FIFO, parameterised depth, with full/empty/count. The FSM, divider and filter stay in `midi_out`.

## Test plan
- Reset: hold `reset` for 3 cycles, then check `uartStream`=1, `busy`=0, `byteInputReady`=1, and the line stays high for 20000 cycles with no input.
- Single byte 0x90 at defaults:
  - Line low for cycles 1–1600 after acceptance.
  - Bits 0,0,0,0,1,0,0,1, each 1600 cycles.
  - Stop bit high for 1600 cycles.
  - `busy` falls exactly 16000 cycles after the start bit.
- Back-to-back with DIVIDER=16, depth 4:
  - Push 0x90,0x3C,0x64,0x80,0x3C,0x00 with valid held high.
  - Ready goes low after the fifth byte is accepted.
  - All six frames are contiguous (no idle between stop and start), and the decoded line equals the input.
- Running status (macro on): push 0x90,0x3C,0x64,0x90,0x3E,0x64,0xF8,0x90,0x40,0xF0,0x90 -> line carries 0x90,0x3C,0x64,0x3E,0x64,0xF8,0x40,0xF0,0x90. With the macro off, all 11 bytes are sent.
- Mid-frame reset: start 0x55 and assert `reset` during bit 3.
  - `uartStream`=1 from the reset edge; `busy`=0.
  - Queued bytes are lost.
  - A following 0xAA is transmitted as a complete, correct frame.
